seg_scan_controller: RTL and testbench

//  Time-multiplexed scan controller for the 4-digit common-anode 7-segment display.

---
 rtl/seg_scan_controller.sv | 143 ++++++++++++++
 tb/tb_seg_scan_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - 4-digit multiplexed 7-segment scan controller
//
// Purpose:
//   Scans four hex digits onto a common-anode 7-segment display one slot at a
//   time. The digit values, decimal points and the blanking enable are
//   captured once per frame, so a value never changes partway through a scan.
//   Leading zeros can be blanked. Brightness is a 16-level PWM applied within
//   each digit slot.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   units        digit 0 value (rightmost)
//   tens         digit 1 value
//   hundreds     digit 2 value
//   thousands    digit 3 value (leftmost)
//   blank_lz     1 = blank leading zeros
//   dp_en        bit i lights the decimal point on digit i
//   brightness   0 = 1/16 duty ... 15 = always on (sampled live)
//   SEG          active-low segments {dp,g,f,e,d,c,b,a}
//   DIGIT        active-low anode enables, bit i = digit i
//   frame_start  one-cycle pulse at the start of each frame
module seg_scan_controller #(
   parameter int TICK_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] units,
   input  logic [3:0] tens,
   input  logic [3:0] hundreds,
   input  logic [3:0] thousands,
   input  logic       blank_lz,
   input  logic [3:0] dp_en,
   input  logic [3:0] brightness,
   output logic [7:0] SEG,
   output logic [3:0] DIGIT,
   output logic       frame_start
);

   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0]   tick;
   logic [1:0]      idx;
   logic [3:0]      pwm;
   logic [3:0][3:0] snap;
   logic [3:0]      snap_dp;
   logic            snap_blank;

   logic            tick_wrap;
   logic            frame_edge;
   logic [3:0]      cur_val;
   logic            zero_above;
   logic            cur_blank;
   logic            lit;
   logic [7:0]      seg_next;
   logic [3:0]      digit_next;

   // Active-low {g,f,e,d,c,b,a}; the DP bit is added separately.
   function automatic logic [6:0] seg_code(input logic [3:0] v);
      case (v)
         4'h0:    seg_code = 7'h40;
         4'h1:    seg_code = 7'h79;
         4'h2:    seg_code = 7'h24;
         4'h3:    seg_code = 7'h30;
         4'h4:    seg_code = 7'h19;
         4'h5:    seg_code = 7'h12;
         4'h6:    seg_code = 7'h02;
         4'h7:    seg_code = 7'h78;
         4'h8:    seg_code = 7'h00;
         4'h9:    seg_code = 7'h10;
         4'hA:    seg_code = 7'h08;
         4'hB:    seg_code = 7'h03;
         4'hC:    seg_code = 7'h46;
         4'hD:    seg_code = 7'h21;
         4'hE:    seg_code = 7'h06;
         default: seg_code = 7'h0E;
      endcase
   endfunction

   always_comb begin
      tick_wrap  = (tick == TICK_LAST);
      frame_edge = tick_wrap && (idx == 2'd3);
      cur_val    = snap[idx];

      // A digit is a leading zero when it and every digit to its left are 0.
      case (idx)
         2'd3:    zero_above = (snap[3] == 4'd0);
         2'd2:    zero_above = (snap[3] == 4'd0) && (snap[2] == 4'd0);
         2'd1:    zero_above = (snap[3] == 4'd0) && (snap[2] == 4'd0) && (snap[1] == 4'd0);
         default: zero_above = 1'b0;
      endcase
      cur_blank = snap_blank && zero_above;

      lit        = (pwm <= brightness);
      seg_next   = 8'hFF;
      digit_next = 4'hF;
      if (lit) begin
         if (!cur_blank) begin
            digit_next = ~(4'b0001 << idx);
            seg_next   = {~snap_dp[idx], seg_code(cur_val)};
         end else if (snap_dp[idx]) begin
            // Blanked digit still shows its decimal point.
            digit_next = ~(4'b0001 << idx);
            seg_next   = 8'h7F;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick        <= TICK_LAST;
         idx         <= 2'd3;
         pwm         <= 4'd0;
         snap        <= '0;
         snap_dp     <= 4'd0;
         snap_blank  <= 1'b0;
         SEG         <= 8'hFF;
         DIGIT       <= 4'hF;
         frame_start <= 1'b0;
      end else begin
         if (tick_wrap) begin
            tick <= '0;
            idx  <= idx + 2'd1;
            pwm  <= 4'd0;
         end else begin
            tick <= tick + 1'b1;
            pwm  <= pwm + 4'd1;
         end

         if (frame_edge) begin
            snap       <= {thousands, hundreds, tens, units};
            snap_dp    <= dp_en;
            snap_blank <= blank_lz;
         end

         frame_start <= (idx == 2'd0) && (tick == '0);
         SEG         <= seg_next;
         DIGIT       <= digit_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - scoreboard bench for seg_scan_controller
module tb_seg_scan_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] units, tens, hundreds, thousands, dp_en, brightness;
   logic       blank_lz;
   logic [7:0] seg4, seg32;
   logic [3:0] dig4, dig32;
   logic       fs4, fs32;

   always #5 clk = ~clk;

   seg_scan_controller #(.TICK_DIV(4)) dut4 (
      .clk(clk), .reset(reset), .units(units), .tens(tens), .hundreds(hundreds),
      .thousands(thousands), .blank_lz(blank_lz), .dp_en(dp_en), .brightness(brightness),
      .SEG(seg4), .DIGIT(dig4), .frame_start(fs4)
   );

   seg_scan_controller #(.TICK_DIV(32)) dut32 (
      .clk(clk), .reset(reset), .units(units), .tens(tens), .hundreds(hundreds),
      .thousands(thousands), .blank_lz(blank_lz), .dp_en(dp_en), .brightness(brightness),
      .SEG(seg32), .DIGIT(dig32), .frame_start(fs32)
   );

   typedef struct {
      logic [7:0] seg;
      logic [3:0] dig;
      logic       fs;
      bit         chk;
      string      tag;
   } exp_t;

   exp_t  q4[$];
   exp_t  q32[$];
   exp_t  e4, e32;
   int    checks = 0;
   int    errors = 0;
   string phase = "init";

   function automatic logic [7:0] code(input logic [3:0] v);
      logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return t[v];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitors: one expectation per cycle, compared at the falling edge.
   always @(negedge clk) begin
      if (q4.size() > 0) begin
         e4 = q4.pop_front();
         if (e4.chk) begin
            chk({phase, " dut4 ", e4.tag, " SEG"},   seg4, e4.seg);
            chk({phase, " dut4 ", e4.tag, " DIGIT"}, dig4, e4.dig);
            chk({phase, " dut4 ", e4.tag, " fs"},    fs4,  e4.fs);
         end
      end
   end

   always @(negedge clk) begin
      if (q32.size() > 0) begin
         e32 = q32.pop_front();
         if (e32.chk) begin
            chk({phase, " dut32 ", e32.tag, " SEG"},   seg32, e32.seg);
            chk({phase, " dut32 ", e32.tag, " DIGIT"}, dig32, e32.dig);
            chk({phase, " dut32 ", e32.tag, " fs"},    fs32,  e32.fs);
         end
      end
   end

   function automatic exp_t mk(input logic [7:0] seg, input logic [3:0] dig,
                               input logic fs, input bit c, input string tag);
      exp_t e;
      e.seg = seg; e.dig = dig; e.fs = fs; e.chk = c; e.tag = tag;
      return e;
   endfunction

   // Expected output for one cycle of slot s (digit value v).
   function automatic exp_t exp_slot(input int s, input logic [3:0] v, input bit dpb,
                                     input bit bl, input bit lit, input bit fs, input string tag);
      exp_t e;
      e = mk(8'hFF, 4'hF, fs, 1'b1, tag);
      if (lit && !(bl && !dpb)) begin
         e.dig = ~(4'b0001 << s);
         e.seg = bl ? 8'h7F : (code(v) & (dpb ? 8'h7F : 8'hFF));
      end
      return e;
   endfunction

   // Each step pushes the expectation for the outputs after the next edge.
   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         @(posedge clk); #1;
         q4.push_back(mk(8'hFF, 4'hF, 1'b0, 1'b1, "reset"));
         q32.push_back(mk(8'hFF, 4'hF, 1'b0, 1'b1, "reset"));
      end
      reset = 1'b0;
      @(posedge clk); #1;
      q4.push_back(mk(8'hFF, 4'hF, 1'b0, 1'b0, "release"));
      q32.push_back(mk(8'hFF, 4'hF, 1'b0, 1'b0, "release"));
   endtask

   task automatic run_slot4(input int s, input logic [3:0] v, input bit dpb, input bit bl, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         q4.push_back(exp_slot(s, v, dpb, bl, (c <= int'(brightness)), (s == 0 && c == 0),
                               $sformatf("s%0d c%0d", s, c)));
      end
   endtask

   task automatic run_slot32(input int s, input logic [3:0] v, input bit dpb, input bit bl);
      for (int c = 0; c < 32; c++) begin
         @(posedge clk); #1;
         q32.push_back(exp_slot(s, v, dpb, bl, ((c % 16) <= int'(brightness)), (s == 0 && c == 0),
                                $sformatf("s%0d c%0d", s, c)));
      end
   endtask

   task automatic run_frame4(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                             input logic [3:0] d3, input logic [3:0] dp, input bit blank);
      bit bl3, bl2, bl1;
      bl3 = blank && (d3 == 4'd0);
      bl2 = bl3 && (d2 == 4'd0);
      bl1 = bl2 && (d1 == 4'd0);
      run_slot4(0, d0, dp[0], 1'b0, 4);
      run_slot4(1, d1, dp[1], bl1, 4);
      run_slot4(2, d2, dp[2], bl2, 4);
      run_slot4(3, d3, dp[3], bl3, 4);
   endtask

   task automatic set_in(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0, input logic [3:0] dp, input logic bl);
      thousands = d3; hundreds = d2; tens = d1; units = d0; dp_en = dp; blank_lz = bl;
   endtask

   initial begin
      set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
      brightness = 4'd15;

      phase = "reset";
      do_reset(3);

      phase = "scan";
      run_frame4(4'd4, 4'd3, 4'd2, 4'd1, 4'b0000, 1'b0);
      run_frame4(4'd4, 4'd3, 4'd2, 4'd1, 4'b0000, 1'b0);

      phase = "snapshot";
      run_slot4(0, 4'd4, 1'b0, 1'b0, 4);
      set_in(4'd5, 4'd6, 4'd7, 4'd8, 4'b0000, 1'b0);
      run_slot4(1, 4'd3, 1'b0, 1'b0, 4);
      run_slot4(2, 4'd2, 1'b0, 1'b0, 4);
      run_slot4(3, 4'd1, 1'b0, 1'b0, 4);
      run_frame4(4'd8, 4'd7, 4'd6, 4'd5, 4'b0000, 1'b0);

      phase = "blank0042";
      set_in(4'd0, 4'd0, 4'd4, 4'd2, 4'b0000, 1'b1);
      run_frame4(4'd8, 4'd7, 4'd6, 4'd5, 4'b0000, 1'b0);
      run_frame4(4'd2, 4'd4, 4'd0, 4'd0, 4'b0000, 1'b1);

      phase = "blank0000";
      set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
      run_frame4(4'd2, 4'd4, 4'd0, 4'd0, 4'b0000, 1'b1);
      run_frame4(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);

      phase = "blank_dp";
      set_in(4'd0, 4'd0, 4'd4, 4'd2, 4'b1000, 1'b1);
      run_frame4(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
      run_frame4(4'd2, 4'd4, 4'd0, 4'd0, 4'b1000, 1'b1);

      phase = "dim4";
      brightness = 4'd1;
      run_frame4(4'd2, 4'd4, 4'd0, 4'd0, 4'b1000, 1'b1);

      phase = "pwm";
      set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0);
      brightness = 4'd0;
      do_reset(2);
      run_slot32(0, 4'd0, 1'b0, 1'b0);
      brightness = 4'd7;
      run_slot32(1, 4'd0, 1'b0, 1'b0);

      phase = "midreset";
      brightness = 4'd15;
      set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
      do_reset(1);
      run_slot4(0, 4'd4, 1'b0, 1'b0, 4);
      run_slot4(1, 4'd3, 1'b0, 1'b0, 4);
      run_slot4(2, 4'd2, 1'b0, 1'b0, 2);
      set_in(4'd9, 4'd8, 4'd7, 4'd6, 4'b0000, 1'b0);
      do_reset(1);
      run_frame4(4'd6, 4'd7, 4'd8, 4'd9, 4'b0000, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      chk("q4 drained", q4.size(), 0);
      chk("q32 drained", q32.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
